// File: rtl/start_sequencer_pkg.sv
// Shared types and constants for the start sequencer: FSM state encoding and
// completed-job counter width.
package start_sequencer_pkg;

    localparam int DONE_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        RUN       = 2'd3
    } state_e;

endpackage

// File: rtl/start_sequencer_fifo.sv
// Tag queue for the start sequencer: power-of-two depth ring buffer with
// registered full/empty flags so downstream ready logic sees no comb path.
module start_sequencer_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage is deliberately not reset; entry validity is carried by count/empty.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/start_sequencer.sv
// Queues tagged start requests and hands them one at a time to a downstream
// counter, reporting each completion with its tag and a running job count.
module start_sequencer
    import start_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int TAG_W        = 4,
    parameter int BUSY_TIMEOUT = 3
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    request__ENA,
    input  logic [TAG_W-1:0]        request_tag,
    output logic                    request__RDY,
    output logic                    startSignal__ENA,
    input  logic                    startSignal__RDY,
    input  logic                    busy,
    input  logic                    busy__RDY,
    output logic                    done__ENA,
    output logic [TAG_W-1:0]        done_tag,
    output logic [DONE_COUNT_W-1:0] done_count,
    output logic                    idle
);

    localparam int              TO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [TAG_W-1:0]        current_tag_q, current_tag_d;
    logic                    done_q, done_d;
    logic [TAG_W-1:0]        done_tag_q, done_tag_d;
    logic [DONE_COUNT_W-1:0] done_count_q, done_count_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] fifo_head;
    logic             start_fire;
    logic             complete;

    start_sequencer_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (request__ENA),
        .push_data (request_tag),
        .pop       (start_fire),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            current_tag_q <= '0;
            done_q        <= 1'b0;
            done_tag_q    <= '0;
            done_count_q  <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            current_tag_q <= current_tag_d;
            done_q        <= done_d;
            done_tag_q    <= done_tag_d;
            done_count_q  <= done_count_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        current_tag_d = current_tag_q;
        done_d        = 1'b0;
        done_tag_d    = done_tag_q;
        done_count_d  = done_count_q;
        to_cnt_d      = to_cnt_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (start_fire) begin
                    state_d       = WAIT_BUSY;
                    current_tag_d = fifo_head;
                    to_cnt_d      = '0;
                end
            end
            WAIT_BUSY: begin
                // A stalled busy__RDY freezes both the transition and the timeout.
                if (busy__RDY) begin
                    if (busy)           state_d  = RUN;
                    else if (!complete) to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (complete) begin
            state_d      = IDLE;
            done_d       = 1'b1;
            done_tag_d   = current_tag_q;
            done_count_d = done_count_q + 1'b1;
            to_cnt_d     = '0;
        end
    end

    always_comb begin
        start_fire = 1'b0;
        complete   = 1'b0;
        case (state_q)
            ISSUE:     start_fire = startSignal__RDY && busy__RDY;
            WAIT_BUSY: complete   = busy__RDY && !busy && (to_cnt_q == TO_LAST);
            RUN:       complete   = busy__RDY && !busy;
            default: ;
        endcase
    end

    assign startSignal__ENA = start_fire;
    assign request__RDY     = !fifo_full;
    assign done__ENA        = done_q;
    assign done_tag         = done_tag_q;
    assign done_count       = done_count_q;
    assign idle             = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_start_sequencer.sv
// Scoreboard bench for start_sequencer: stimulus pushes expected tags, a
// monitor pops and compares on every done__ENA; a small counter model drives busy.
module tb_start_sequencer;
    import start_sequencer_pkg::*;

    localparam int FIFO_DEPTH   = 4;
    localparam int TAG_W        = 4;
    localparam int BUSY_TIMEOUT = 3;

    logic                    CLK = 1'b0;
    logic                    nRST;
    logic                    request__ENA;
    logic [TAG_W-1:0]        request_tag;
    logic                    request__RDY;
    logic                    startSignal__ENA;
    logic                    startSignal__RDY;
    logic                    busy;
    logic                    busy__RDY;
    logic                    done__ENA;
    logic [TAG_W-1:0]        done_tag;
    logic [DONE_COUNT_W-1:0] done_count;
    logic                    idle;

    logic cnt_busy  = 1'b0;
    logic rdy_block = 1'b0;
    int   busy_len  = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cnt = 0;
    int done_seen = 0;
    int last_start_cyc = 0;
    int last_lat = 0;
    logic [TAG_W-1:0]        exp_q [$];
    logic [DONE_COUNT_W-1:0] exp_count = '0;
    logic [TAG_W-1:0]        mon_tag;

    assign startSignal__RDY = !cnt_busy && !rdy_block;
    assign busy             = cnt_busy;

    start_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .TAG_W        (TAG_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .CLK              (CLK),
        .nRST             (nRST),
        .request__ENA     (request__ENA),
        .request_tag      (request_tag),
        .request__RDY     (request__RDY),
        .startSignal__ENA (startSignal__ENA),
        .startSignal__RDY (startSignal__RDY),
        .busy             (busy),
        .busy__RDY        (busy__RDY),
        .done__ENA        (done__ENA),
        .done_tag         (done_tag),
        .done_count       (done_count),
        .idle             (idle)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol check on start, scoreboard compare on done.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (startSignal__ENA) begin
                check("start_needs_rdy", startSignal__RDY, 1);
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (done__ENA) begin
                done_seen++;
                last_lat = cyc - last_start_cyc - 1;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", done__ENA, 0);
                end else begin
                    mon_tag = exp_q.pop_front();
                    exp_count++;
                    check("done_tag", done_tag, mon_tag);
                    check("done_count", done_count, exp_count);
                end
            end
        end
    end

    // Downstream counter model: busy rises the cycle after a start, lasts busy_len cycles.
    initial begin
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1 && startSignal__ENA && busy_len > 0) begin
                @(posedge CLK);
                #1 cnt_busy = 1'b1;
                repeat (busy_len) @(posedge CLK);
                #1 cnt_busy = 1'b0;
            end
        end
    end

    task automatic enqueue(input logic [TAG_W-1:0] tag);
        int t = 0;
        while (!request__RDY && t < 200) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (!request__RDY) begin
            check("enqueue_rdy_timeout", request__RDY, 1);
        end else begin
            request__ENA = 1'b1;
            request_tag  = tag;
            exp_q.push_back(tag);
            @(posedge CLK);
            #1;
            request__ENA = 1'b0;
        end
    endtask

    task automatic wait_done(input int n, input string name);
        int t = 0;
        while (done_seen < n && t < 500) begin
            @(negedge CLK);
            t++;
        end
        check(name, done_seen, n);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        nRST         = 1'b0;
        request__ENA = 1'b0;
        request_tag  = '0;
        busy__RDY    = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_req_rdy",   request__RDY, 1);
        check("rst_start_ena", startSignal__ENA, 0);
        check("rst_done_ena",  done__ENA, 0);
        check("rst_done_tag",  done_tag, 0);
        check("rst_done_cnt",  done_count, 0);
        check("rst_idle",      idle, 1);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Single job, counter busy for 22 cycles.
        busy_len = 22;
        enqueue(4'd5);
        wait_done(1, "single_done");
        check("single_starts", start_cnt, 1);
        check("single_count", done_count, 1);
        repeat (2) @(posedge CLK);
        #1;
        check("single_idle", idle, 1);

        // Back-to-back fill with the counter blocked; fifth request waits for a slot.
        busy_len  = 2;
        rdy_block = 1'b1;
        for (int i = 1; i <= 4; i++) enqueue(TAG_W'(i));
        check("b2b_full_rdy_low", request__RDY, 0);
        check("b2b_no_start", start_cnt, 1);
        request__ENA = 1'b1;
        request_tag  = 4'd9;
        @(posedge CLK);
        #1;
        request__ENA = 1'b0;
        check("b2b_ignored_push", request__RDY, 0);
        rdy_block = 1'b0;
        enqueue(4'd5);
        wait_done(6, "b2b_done");

        // Enqueue and pop on the same edge keep occupancy unchanged.
        busy_len  = 20;
        rdy_block = 1'b1;
        enqueue(4'd10);
        enqueue(4'd11);
        request__ENA = 1'b1;
        request_tag  = 4'd12;
        exp_q.push_back(4'd12);
        rdy_block = 1'b0;
        @(posedge CLK);
        #1;
        request__ENA = 1'b0;
        enqueue(4'd13);
        check("simul_rdy_at_3", request__RDY, 1);
        enqueue(4'd14);
        check("simul_full_at_4", request__RDY, 0);
        busy_len = 2;
        wait_done(11, "simul_done");

        // Backpressure: ISSUE holds with no start until the counter is ready.
        rdy_block = 1'b1;
        enqueue(4'd6);
        base = start_cnt;
        repeat (10) begin
            @(negedge CLK);
            check("bp_no_start", startSignal__ENA, 0);
        end
        check("bp_start_cnt", start_cnt, base);
        check("bp_rdy_held", request__RDY, 1);
        check("bp_not_idle", idle, 0);
        @(posedge CLK);
        #1 rdy_block = 1'b0;
        @(negedge CLK);
        check("bp_fire_first", startSignal__ENA, 1);
        wait_done(12, "bp_done");

        // Timeout: busy never rises.
        busy_len = 0;
        enqueue(4'd7);
        wait_done(13, "timeout_done");
        check("timeout_latency", last_lat, BUSY_TIMEOUT);

        // busy__RDY low for 5 cycles in WAIT_BUSY stretches the timeout.
        base = start_cnt;
        enqueue(4'd8);
        t = 0;
        while (start_cnt == base && t < 100) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check("freeze_started", start_cnt, base + 1);
        busy__RDY = 1'b0;
        repeat (5) @(posedge CLK);
        #1 busy__RDY = 1'b1;
        wait_done(14, "freeze_done");
        check("freeze_latency", last_lat, BUSY_TIMEOUT + 5);

        // Completed-count wrap from 16'hFFFF.
        force dut.done_count_q = 16'hFFFF;
        @(posedge CLK);
        #1;
        release dut.done_count_q;
        exp_count = 16'hFFFF;
        @(posedge CLK);
        #1;
        check("wrap_preload", done_count, 16'hFFFF);
        busy_len = 1;
        enqueue(4'd3);
        wait_done(15, "wrap_done");
        check("wrap_zero", done_count, 0);

        // Reset while RUN with two requests queued.
        busy_len = 30;
        enqueue(4'd2);
        repeat (4) @(posedge CLK);
        #1;
        enqueue(4'd11);
        enqueue(4'd12);
        #2 nRST = 1'b0;
        #1;
        exp_q.delete();
        exp_count = '0;
        check("rrun_req_rdy",   request__RDY, 1);
        check("rrun_start_ena", startSignal__ENA, 0);
        check("rrun_done_ena",  done__ENA, 0);
        check("rrun_done_tag",  done_tag, 0);
        check("rrun_done_cnt",  done_count, 0);
        check("rrun_idle",      idle, 1);
        base = done_seen;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        t = start_cnt;
        repeat (40) @(posedge CLK);
        #1;
        check("rrun_no_done", done_seen, base);
        check("rrun_no_start", start_cnt, t);
        check("rrun_still_idle", idle, 1);
        busy_len = 1;
        enqueue(4'd4);
        wait_done(base + 1, "rrun_fresh_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of queued start requests (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, width of request tag.
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 3, cycles to wait for busy rise after issue.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLK input 1 (all state on rising edge); nRST input 1 (asynchronous, active-low).
REQ-005 SHALL have request__ENA  input  1  upstream enqueue strobe.
REQ-006 SHALL have request_tag  input  TAG_W  tag captured with request.
REQ-007 SHALL have request__RDY  output  1  high when FIFO not full.
REQ-008 SHALL have startSignal__ENA  output  1  one-cycle start strobe to downstream counter.
REQ-009 SHALL have startSignal__RDY  input  1  counter idle (count == 0).
REQ-010 SHALL have busy, busy__RDY  input  1 each  counter running / busy valid.
REQ-011 SHALL have done__ENA  output  1  one-cycle completion pulse.
REQ-012 SHALL have done_tag  output  TAG_W  tag of completed job, valid with done__ENA.
REQ-013 SHALL have done_count  output  16  completed-job count.
REQ-014 SHALL have idle  output  1  high when state IDLE and FIFO empty.

Function
REQ-015 SHALL enqueue request_tag on a rising CLK where request__ENA && request__RDY; request__ENA while !request__RDY is ignored.
REQ-016 SHALL derive request__RDY from registered FIFO occupancy only; a dequeue in the same cycle does not free a slot for that cycle.
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT_BUSY -> RUN -> IDLE.
REQ-018 IDLE: go to ISSUE when FIFO non-empty (registered); a request enqueued while empty is issued no earlier than 2 cycles after enqueue.
REQ-019 ISSUE: assert startSignal__ENA combinationally only when startSignal__RDY && busy__RDY; on that cycle pop FIFO head into current_tag and go WAIT_BUSY; otherwise hold.
REQ-020 startSignal__ENA SHALL never be high without startSignal__RDY, and SHALL be high for exactly one cycle per popped request.
REQ-021 WAIT_BUSY: on busy && busy__RDY go RUN; if BUSY_TIMEOUT cycles elapse without busy, treat job as complete (zero-length count) and perform completion (REQ-023).
REQ-022 RUN: on !busy && busy__RDY perform completion.
REQ-023 Completion SHALL, in one cycle: pulse done__ENA, drive done_tag = current_tag, increment done_count (wrap 16'hFFFF -> 0), return to IDLE.
REQ-024 SHALL keep jobs strictly FIFO-ordered; done_tag sequence equals enqueue order.
REQ-025 Simultaneous enqueue and ISSUE pop SHALL both take effect; occupancy unchanged.
REQ-026 busy__RDY low SHALL freeze WAIT_BUSY/RUN transitions and the timeout counter.

Reset
REQ-027 nRST low SHALL asynchronously force: state IDLE, FIFO empty, request__RDY 1, startSignal__ENA 0, done__ENA 0, done_tag 0, done_count 0, idle 1, timeout counter 0.
REQ-028 Reset mid-job SHALL drop queued and in-flight tags with no done__ENA; first post-reset issue requires a fresh enqueue.

Structure
REQ-029 SHALL place FSM state enum (IDLE, ISSUE, WAIT_BUSY, RUN) and DONE_COUNT_W = 16 in package start_sequencer_pkg.
REQ-030 SHALL implement the tag queue as sub-module start_sequencer_fifo (parameterized width/depth, registered full/empty, same CLK/nRST).

Verification
REQ-031 Single job: enqueue tag 5, counter RDY, busy high 22 cycles -> one startSignal__ENA, one done__ENA with done_tag 5, done_count 1.
REQ-032 Back-to-back: enqueue tags 1,2,3,4,5 consecutively, depth 4 -> request__RDY low after 4th, 5th held; done_tags 1,2,3,4,5 in order.
REQ-033 Backpressure: startSignal__RDY held low 10 cycles in ISSUE -> no startSignal__ENA, FIFO unchanged; ENA fires first cycle RDY rises.
REQ-034 Timeout: busy never rises after issue of tag 7 -> done__ENA with tag 7 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry.
REQ-035 Reset in RUN with 2 queued -> all outputs at reset values, no done__ENA, idle 1, request__RDY 1.
REQ-036 Wrap: preload done_count to 16'hFFFF via 65535 timeout jobs (or force) -> next completion gives done_count 0.
